enemy_attack_scheduler: RTL and testbench
=========================================

// Module: enemy_attack_scheduler
// PURPOSE
//  Schedules the shared enemy_attackROM between ENEMY_NUM enemy_attack requesters. At most one enemy projectile is live at a time.
//  Round-robin grant to alive enemies whose attack is ready, then a frame-based cooldown. Muxes the granted requester's ROM
//  address / is_obj to the single enemy_attackROM and color_mapper. Replaces the fixed-priority mux in the top level.
// PARAMETERS
//  N               4   number of requesters (ENEMY_NUM)
//  ADDR_W          9   enemy_attackROM address width
//  COOLDOWN_FRAMES 30  game frames idle after a projectile ends (0 allowed)
//  GRANT_TIMEOUT   8   game frames to wait for Attack_On after grant
// PORTS
//  Clk                        in   1           system clock (CLOCK_50)
//  Reset                      in   1           asynchronous, active-high reset
//  game_frame_clk_rising_edge in   1           one-cycle game frame tick
//  Game_Over_On               in   1           game over; blocks new grants
//  Enemy_Alive                in   N           bit i = enemy i alive
//  Attack_Req                 in   N           bit i = Enemy_Attack_Ready[i]
//  Attack_On                  in   N           bit i = enemy_attack i projectile live
//  Attack_Address_In          in   N*ADDR_W    requester i at [i*ADDR_W +: ADDR_W]
//  Is_Obj_In                  in   N           bit i = is_enemy_attack[i]
//  Attack_Grant               out  N           one-hot permission to fire; level, GRANT state only
//  Sel_Id                     out  $clog2(N)   registered id of current owner
//  Sel_Valid                  out  1           1 in ACTIVE state
//  Rom_Address                out  ADDR_W      to enemy_attackROM read_address
//  Is_Obj_Out                 out  1           to color_mapper is_enemy_attack
//  Conflict                   out  1           one-cycle pulse: a non-owner Attack_On seen
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rr_ptr=0, Sel_Id=0, cooldown cnt=0, timeout cnt=0, all outputs 0.
//  eligible[i] = Attack_Req[i] & Enemy_Alive[i].
//  IDLE: if !Game_Over_On and |eligible: pick first eligible scanning rr_ptr, rr_ptr+1, ... (mod N).
//   Next edge: Sel_Id<=pick, timeout cnt<=0, state<=GRANT. Otherwise stay.
//  GRANT: Attack_Grant = 1<<Sel_Id. Checks use this priority:
//   1) Game_Over_On or !Enemy_Alive[Sel_Id] -> IDLE, rr_ptr<=Sel_Id+1.
//   2) Attack_On[Sel_Id] -> ACTIVE.
//   3) frame tick -> timeout cnt+1; when it reaches GRANT_TIMEOUT -> COOLDOWN, rr_ptr<=Sel_Id+1.
//  ACTIVE: Sel_Valid=1. Rom_Address / Is_Obj_Out come from requester Sel_Id through a combinational mux (zero latency).
//   Enemy death and Game_Over_On do not abort ACTIVE; the projectile finishes.
//   When Attack_On[Sel_Id]==0: state<=COOLDOWN, cnt<=COOLDOWN_FRAMES, rr_ptr<=Sel_Id+1.
//  COOLDOWN: cnt-1 on each frame tick. If cnt==0 -> IDLE next cycle (COOLDOWN_FRAMES=0 gives one idle cycle).
//  Outside ACTIVE: Rom_Address=0, Is_Obj_Out=0.
//  Conflict: registered pulse when Attack_On[i]=1 for any i != Sel_Id while in ACTIVE, or any Attack_On bit in IDLE/COOLDOWN.
//   Conflict is diagnostic only; it does not change state.
//  rr_ptr wraps N-1 -> 0. Counters saturate; they never wrap.
//  A Req and a frame tick in the same cycle need no special handling; only the Clk edge matters.
// TESTING
//  1 Reset mid-ACTIVE with Sel_Id=2 -> next cycle all outputs 0, state IDLE, rr_ptr 0.
//  2 Req=4'b1111, all alive, rr_ptr=0 -> successive grants go 0,1,2,3,0.
//   Each grant follows Attack_On high for 5 frames, then low, with COOLDOWN_FRAMES=2.
//  3 Req=4'b0101 with enemy 0 dead -> grant 4'b0100, Sel_Id=2.
//   In ACTIVE, Rom_Address equals Attack_Address_In[2] every cycle.
//  4 Grant to 1, Attack_On never rises -> after 8 frame ticks go to COOLDOWN.
//   Attack_Grant=0 and rr_ptr=2.
//  5 Game_Over_On during GRANT -> IDLE next cycle and no further grants.
//   Game_Over_On during ACTIVE -> ACTIVE holds until Attack_On falls.
//  6 Owner 0 ACTIVE and Attack_On[3] forced high -> Conflict pulses 1 cycle.
//   Rom_Address still equals Attack_Address_In[0].

Source files
------------

// File: rtl/enemy_attack_scheduler.sv
// Arbitrates the shared enemy attack ROM among N requesters: round-robin grant, wait for the
// projectile to go live, mux its ROM address, then hold off for a frame-based cooldown.
module enemy_attack_scheduler #(
  parameter int unsigned N               = 4,
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned GRANT_TIMEOUT   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  game_frame_clk_rising_edge_i,
  input  logic                  game_over_on_i,
  input  logic [N-1:0]          enemy_alive_i,
  input  logic [N-1:0]          attack_req_i,
  input  logic [N-1:0]          attack_on_i,
  input  logic [N*ADDR_W-1:0]   attack_address_in_i,
  input  logic [N-1:0]          is_obj_in_i,
  output logic [N-1:0]          attack_grant_o,
  output logic [$clog2(N)-1:0]  sel_id_o,
  output logic                  sel_valid_o,
  output logic [ADDR_W-1:0]     rom_address_o,
  output logic                  is_obj_out_o,
  output logic                  conflict_o
);

  localparam int unsigned IdW = $clog2(N);
  localparam int unsigned CdW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int unsigned ToW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
  localparam logic [CdW-1:0] CdInit  = CdW'(COOLDOWN_FRAMES);
  localparam logic [ToW-1:0] ToLimit = ToW'(GRANT_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGrant, StActive, StCooldown} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   sel_id_q, sel_id_d;
  logic [CdW-1:0]   cd_cnt_q, cd_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             conflict_q, conflict_d;

  logic [N-1:0]     eligible;
  logic [N-1:0]     owner_oh;
  logic             pick_valid;
  logic [IdW-1:0]   pick_id;
  logic [ADDR_W-1:0] owner_addr;

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    if (id == IdW'(N - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  assign eligible   = attack_req_i & enemy_alive_i;
  assign owner_oh   = N'(1) << sel_id_q;
  assign owner_addr = attack_address_in_i[32'(sel_id_q) * ADDR_W +: ADDR_W];

  // First eligible requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    logic [IdW-1:0] idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdW'((32'(rr_ptr_q) + k) % N);
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    sel_id_d       = sel_id_q;
    cd_cnt_d       = cd_cnt_q;
    to_cnt_d       = to_cnt_q;
    conflict_d     = 1'b0;
    attack_grant_o = '0;
    sel_valid_o    = 1'b0;
    rom_address_o  = '0;
    is_obj_out_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        conflict_d = |attack_on_i;
        if (!game_over_on_i && pick_valid) begin
          sel_id_d = pick_id;
          to_cnt_d = '0;
          state_d  = StGrant;
        end
      end

      StGrant: begin
        attack_grant_o = owner_oh;
        if (game_over_on_i || !enemy_alive_i[sel_id_q]) begin
          state_d  = StIdle;
          rr_ptr_d = next_id(sel_id_q);
        end else if (attack_on_i[sel_id_q]) begin
          state_d = StActive;
        end else if (game_frame_clk_rising_edge_i) begin
          if (to_cnt_q != ToLimit) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
          if (to_cnt_d == ToLimit) begin
            state_d  = StCooldown;
            rr_ptr_d = next_id(sel_id_q);
          end
        end
      end

      // Death and game over are ignored here so the live projectile can finish.
      StActive: begin
        sel_valid_o   = 1'b1;
        rom_address_o = owner_addr;
        is_obj_out_o  = is_obj_in_i[sel_id_q];
        conflict_d    = |(attack_on_i & ~owner_oh);
        if (!attack_on_i[sel_id_q]) begin
          state_d  = StCooldown;
          cd_cnt_d = CdInit;
          rr_ptr_d = next_id(sel_id_q);
        end
      end

      StCooldown: begin
        conflict_d = |attack_on_i;
        if (cd_cnt_q == '0) begin
          state_d = StIdle;
        end else if (game_frame_clk_rising_edge_i) begin
          cd_cnt_d = cd_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      sel_id_q   <= '0;
      cd_cnt_q   <= '0;
      to_cnt_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_id_q   <= sel_id_d;
      cd_cnt_q   <= cd_cnt_d;
      to_cnt_q   <= to_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign sel_id_o   = sel_id_q;
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_enemy_attack_scheduler.sv
// Scenario bench for enemy_attack_scheduler: expected grant ids are queued as stimulus is set
// up and popped when the DUT raises a grant.
module tb_enemy_attack_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          game_over = 1'b0;
  logic [3:0]    alive = 4'h0;
  logic [3:0]    req = 4'h0;
  logic [3:0]    attack_on = 4'h0;
  logic [35:0]   addr_in = '0;
  logic [3:0]    is_obj_in = 4'h0;
  logic [3:0]    grant;
  logic [1:0]    sel_id;
  logic          sel_valid;
  logic [8:0]    rom_addr;
  logic          is_obj_out;
  logic          conflict;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  enemy_attack_scheduler #(
    .N               (N),
    .ADDR_W          (AW),
    .COOLDOWN_FRAMES (2),
    .GRANT_TIMEOUT   (8)
  ) dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .game_frame_clk_rising_edge_i (tick),
    .game_over_on_i               (game_over),
    .enemy_alive_i                (alive),
    .attack_req_i                 (req),
    .attack_on_i                  (attack_on),
    .attack_address_in_i          (addr_in),
    .is_obj_in_i                  (is_obj_in),
    .attack_grant_o               (grant),
    .sel_id_o                     (sel_id),
    .sel_valid_o                  (sel_valid),
    .rom_address_o                (rom_addr),
    .is_obj_out_o                 (is_obj_out),
    .conflict_o                   (conflict)
  );

  always #5 clk = ~clk;

  // Frame tick: one cycle in every four.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      tick = (div == 0);
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int cnt;
    cnt = 0;
    while (cnt < n) begin
      @(posedge clk);
      if (tick) cnt++;
    end
  endtask

  // Returns at the first negedge with a grant; ticks counts frame ticks after the first edge.
  task automatic wait_grant(output logic [3:0] g, output int ticks, output bit ok);
    g = '0;
    ticks = 0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (tick && c > 0) ticks++;
      @(negedge clk);
      if (grant !== 4'h0) begin
        g = grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if ({grant, sel_id, sel_valid, rom_addr, is_obj_out, conflict} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h required 0",
               {grant, sel_id, sel_valid, rom_addr, is_obj_out, conflict});
    end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    alive = 4'hF;
    req = 4'hF;
    for (int i = 0; i < 5; i++) exp_q.push_back(i % 4);
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, t, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g !== 4'(1 << e)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b required %b", i, g, 4'(1 << e));
        break;
      end
      checks++;
      if (sel_id !== 2'(e)) begin
        failures++;
        $display("FAIL rr_sel_id[%0d]: got %0d required %0d", i, sel_id, e);
      end
      checks++;
      if (rom_addr !== 9'd0 || sel_valid !== 1'b0) begin
        failures++;
        $display("FAIL grant_outputs[%0d]: got rom=%0h valid=%b required 0/0", i, rom_addr, sel_valid);
      end
      if (i > 0) begin
        checks++;
        if (t !== 2) begin
          failures++;
          $display("FAIL cooldown_ticks[%0d]: got %0d required 2", i, t);
        end
      end
      attack_on = 4'(1 << e);
      @(negedge clk);
      checks++;
      if (sel_valid !== 1'b1 || grant !== 4'h0) begin
        failures++;
        $display("FAIL active_entry[%0d]: got valid=%b grant=%b required 1/0000", i, sel_valid, grant);
      end
      wait_ticks(5);
      @(negedge clk);
      attack_on = 4'h0;
      if (i == 4) req = 4'h0;
    end
    wait_cycles(20);
  endtask

  task automatic test_rom_mux();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    alive = 4'b1110;
    req = 4'b0101;
    addr_in = 36'h1_2345_6789;
    is_obj_in = 4'b0100;
    exp_q.push_back(2);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e) || sel_id !== 2'(e)) begin
      failures++;
      $display("FAIL dead_skip_grant: got %b id=%0d required %b id=%0d", g, sel_id, 4'(1 << e), e);
    end
    attack_on = 4'b0100;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (rom_addr !== addr_in[2*AW +: AW] || is_obj_out !== is_obj_in[2]) begin
        failures++;
        $display("FAIL rom_mux[%0d]: got %0h/%b required %0h/%b", j, rom_addr, is_obj_out,
                 addr_in[2*AW +: AW], is_obj_in[2]);
      end
      addr_in = 36'({$urandom(), $urandom()});
      is_obj_in = 4'($urandom());
      #1;
      checks++;
      if (rom_addr !== addr_in[2*AW +: AW] || is_obj_out !== is_obj_in[2]) begin
        failures++;
        $display("FAIL rom_mux_comb[%0d]: got %0h/%b required %0h/%b", j, rom_addr, is_obj_out,
                 addr_in[2*AW +: AW], is_obj_in[2]);
      end
    end
    @(negedge clk);
    attack_on = 4'h0;
    req = 4'h0;
    alive = 4'hF;
    @(negedge clk);
    checks++;
    if (rom_addr !== 9'd0 || is_obj_out !== 1'b0) begin
      failures++;
      $display("FAIL rom_idle_zero: got %0h/%b required 0/0", rom_addr, is_obj_out);
    end
    wait_cycles(20);
  endtask

  task automatic test_timeout();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    int ticks;
    req = 4'b0010;
    exp_q.push_back(1);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e)) begin
      failures++;
      $display("FAIL timeout_grant: got %b required %b", g, 4'(1 << e));
    end
    ticks = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (tick) ticks++;
      @(negedge clk);
      if (grant === 4'h0) break;
    end
    checks++;
    if (ticks !== 8 || grant !== 4'h0) begin
      failures++;
      $display("FAIL timeout_ticks: got %0d grant=%b required 8/0000", ticks, grant);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      failures++;
      $display("FAIL timeout_rr_ptr: got %0d required 2", dut.rr_ptr_q);
    end
    req = 4'h0;
    wait_cycles(20);
  endtask

  task automatic test_game_over();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    int seen;
    req = 4'b0001;
    exp_q.push_back(0);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e)) begin
      failures++;
      $display("FAIL go_grant: got %b required %b", g, 4'(1 << e));
    end
    game_over = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'h0 || dut.rr_ptr_q !== 2'd1) begin
      failures++;
      $display("FAIL go_abort: got grant=%b rr=%0d required 0000/1", grant, dut.rr_ptr_q);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (grant !== 4'h0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL go_blocks: got %0d grant cycles required 0", seen);
    end
    game_over = 1'b0;
    exp_q.push_back(0);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e)) begin
      failures++;
      $display("FAIL go_regrant: got %b required %b", g, 4'(1 << e));
    end
    attack_on = 4'b0001;
    @(negedge clk);
    game_over = 1'b1;
    alive = 4'b1110;
    wait_cycles(12);
    checks++;
    if (sel_valid !== 1'b1 || sel_id !== 2'd0) begin
      failures++;
      $display("FAIL go_active_holds: got valid=%b id=%0d required 1/0", sel_valid, sel_id);
    end
    attack_on = 4'h0;
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (sel_valid !== 1'b0) begin
      failures++;
      $display("FAIL go_active_ends: got valid=%b required 0", sel_valid);
    end
    game_over = 1'b0;
    alive = 4'hF;
    wait_cycles(20);
  endtask

  task automatic test_conflict();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    req = 4'b0001;
    addr_in = 36'h0_0000_01A5;
    is_obj_in = 4'b0001;
    exp_q.push_back(0);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e)) begin
      failures++;
      $display("FAIL conf_grant: got %b required %b", g, 4'(1 << e));
    end
    attack_on = 4'b0001;
    @(negedge clk);
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conf_quiet: got %b required 0", conflict);
    end
    attack_on = 4'b1001;
    @(negedge clk);
    checks++;
    if (conflict !== 1'b1 || sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL conf_pulse: got %b valid=%b required 1/1", conflict, sel_valid);
    end
    checks++;
    if (rom_addr !== 9'h1A5) begin
      failures++;
      $display("FAIL conf_rom: got %0h required 1a5", rom_addr);
    end
    attack_on = 4'b0001;
    @(negedge clk);
    checks++;
    if (conflict !== 1'b0) begin
      failures++;
      $display("FAIL conf_one_cycle: got %b required 0", conflict);
    end
    attack_on = 4'h0;
    req = 4'h0;
    wait_cycles(20);
  endtask

  task automatic test_reset_mid_active();
    logic [3:0] g;
    int t;
    bit ok;
    int e;
    req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(g, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== 4'(1 << e)) begin
      failures++;
      $display("FAIL rst_grant: got %b required %b", g, 4'(1 << e));
    end
    attack_on = 4'b0100;
    @(negedge clk);
    checks++;
    if (sel_valid !== 1'b1 || sel_id !== 2'd2) begin
      failures++;
      $display("FAIL rst_pre_active: got valid=%b id=%0d required 1/2", sel_valid, sel_id);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, sel_id, sel_valid, rom_addr, is_obj_out, conflict} !== '0) begin
      failures++;
      $display("FAIL rst_async_outputs: got %0h required 0",
               {grant, sel_id, sel_valid, rom_addr, is_obj_out, conflict});
    end
    checks++;
    if (dut.state_q !== 2'd0 || dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL rst_state: got state=%0d rr=%0d required 0/0", dut.state_q, dut.rr_ptr_q);
    end
    attack_on = 4'h0;
    req = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rom_mux();
    test_timeout();
    test_game_over();
    test_conflict();
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
